map_scroller: RTL and testbench
===============================

Name: map_scroller

Overview:
- Downstream consumer of the map-timing stage's move_map pulse in the delivery game.
- Holds the scrolling lane map: obstacle plane plus package plane. Each move_map pulse shifts the map one row toward the player and inserts a new pseudo-random top row.
- Detects collisions and package pickups at the player row, and keeps score and lives.
- Drives count_map back to the map-timing stage, so map timers run only while a game is active.

Parameters:
- LANES, 4, number of lanes; player_lane width is $clog2(LANES).
- ROWS, 8, number of map rows; row 0 is the player row, row ROWS-1 is the insertion row.
- LIVES, 3, lives at game start (1..7).
- SCORE_W, 8, score width.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level, sampled each cycle; starts or restarts a game.
- move_map  in  1  one-cycle pulse from the map-timing stage.
- player_lane  in  $clog2(LANES)  current player lane.
- load_valid  in  1  test/debug: force the next inserted row.
- load_obst  in  LANES  forced obstacle row.
- load_pkg  in  LANES  forced package row.
- count_map  out  1  high while state is RUN.
- obstacles  out  ROWS*LANES  obstacle plane; bit r*LANES+l = row r, lane l.
- packages  out  ROWS*LANES  package plane, same layout.
- score  out  SCORE_W  packages collected.
- lives  out  3  remaining lives.
- hit  out  1  one-cycle pulse on collision.
- pickup  out  1  one-cycle pulse on package collection.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; obstacles=0; packages=0; score=0; lives=LIVES.
  - hit=pickup=game_over=count_map=0; LFSR=SEED; load latch cleared.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle after reset, regardless of state.
- States:
  - IDLE: start=1 -> RUN next cycle.
  - RUN: count_map=1.
  - OVER: game_over=1; start=1 -> RUN, with map, score and lives re-initialised in the same transition cycle.
- Load latch:
  - load_valid=1 captures load_obst/load_pkg into a one-entry latch; a later load overwrites it.
  - The latch is consumed and cleared by the next shift.
- Shift (RUN and move_map=1), effective next edge:
  - row[i] <= row[i+1] for i < ROWS-1; row 0 is discarded.
  - row[ROWS-1] <= latch contents if the latch is valid, else the generated row.
- Generated row:
  - Obstacle in lane lfsr[1:0] mod LANES when lfsr[3:2]!=0, otherwise no obstacle.
  - Package in lane lfsr[5:4] mod LANES when lfsr[6]=1, otherwise no package.
  - If the package lane equals the obstacle lane, the package is dropped.
  - At most one obstacle per generated row; forced rows are taken verbatim.
- Evaluation (RUN only, every cycle, on current registers before any shift):
  - Collision when obstacles[player_lane] in row 0 is 1.
  - Pickup when packages[player_lane] in row 0 is 1.
- On collision:
  - hit pulses next cycle; lives decrements.
  - Row-0 obstacle bit at player_lane clears, unless a shift happens in the same cycle (shift wins; the row is discarded anyway). This prevents double counting.
  - If lives was 1, lives becomes 0 and next state is OVER; no further evaluation.
- On pickup:
  - pickup pulses next cycle; score increments, saturating at 2^SCORE_W-1.
  - Bit cleared under the same rule as collision.
- Collision and pickup in the same cycle: only possible with forced rows; both are processed.
- move_map ignored in IDLE and OVER; map frozen.
- start held high in RUN has no effect.
- player_lane >= LANES: no evaluation that cycle.
- Reset mid-game returns to IDLE immediately with reset values.

Decomposition:
- Shared package delivery_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, OVER=2'd2)
  - LFSR tap constant
  - default LANES/ROWS
- One sub-module: lfsr_16 (clock, reset, seed parameter, 16-bit out).
- Row generation and map shifting stay in map_scroller.

Test Plan:
- Reset then no start, 20 move_map pulses -> obstacles=0, packages=0, count_map=0, lives=3, score=0.
- start=1, load row obst=4'b0100, pkg=0, player_lane=2, 8 move_map pulses -> after the 8th shift, hit pulses once; lives=2; row-0 obstacle bit at lane 2 clears; no second hit while idle in lane 2.
- Load pkg=4'b0001 and shift to row 0 with player_lane=0 -> pickup pulses, score=1; player_lane=1 instead -> no pickup, and the package leaves on the next shift.
- Three forced collisions with LIVES=3 -> lives=0, game_over=1, count_map=0; further move_map leaves the map unchanged; start=1 -> RUN, lives=3, score=0, map=0.
- Obstacle at row 0 in lane 1, player_lane=1, move_map in the same cycle -> hit=1, lives decremented once, the map shifts normally.
- score at 255 and another pickup -> score stays 255, pickup still pulses.

Source files
------------

// File: rtl/delivery_pkg.sv
// Shared definitions for the delivery game datapath.
// Holds the game state encoding, the LFSR feedback tap mask and the
// default map geometry used by map_scroller.
package delivery_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_LANES = 4;
    localparam int DEF_ROWS  = 8;

endpackage

// File: rtl/lfsr_16.sv
// 16-bit Fibonacci LFSR, free running from reset release.
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset, loads SEED
//   lfsr  - current register value
module lfsr_16
    import delivery_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic feedback;

    assign feedback = ^(lfsr & LFSR_TAPS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/map_scroller.sv
// Scrolling lane map for the delivery game.
// Holds the obstacle and package planes, shifts them one row toward the
// player on each move_map pulse, inserts a forced or pseudo-random top
// row, and tracks collisions, pickups, score and lives.
// Ports:
//   clock, reset          - clock and asynchronous active-low reset
//   start                 - level, starts a game from IDLE or OVER
//   move_map              - one-cycle scroll pulse
//   player_lane           - lane the player occupies
//   load_valid/obst/pkg   - force the next inserted row
//   count_map             - high while a game is running
//   obstacles, packages   - map planes, bit r*LANES+l = row r, lane l
//   score, lives          - game counters
//   hit, pickup           - one-cycle event pulses
//   game_over             - high once lives are exhausted
module map_scroller
    import delivery_pkg::*;
#(
    parameter int          LANES   = DEF_LANES,
    parameter int          ROWS    = DEF_ROWS,
    parameter int          LIVES   = 3,
    parameter int          SCORE_W = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       move_map,
    input  logic [$clog2(LANES)-1:0]   player_lane,
    input  logic                       load_valid,
    input  logic [LANES-1:0]           load_obst,
    input  logic [LANES-1:0]           load_pkg,
    output logic                       count_map,
    output logic [ROWS*LANES-1:0]      obstacles,
    output logic [ROWS*LANES-1:0]      packages,
    output logic [SCORE_W-1:0]         score,
    output logic [2:0]                 lives,
    output logic                       hit,
    output logic                       pickup,
    output logic                       game_over
);

    localparam int          MAP_W      = ROWS * LANES;
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state;
    logic [15:0]        lfsr;
    logic               latch_vld;
    logic [LANES-1:0]   latch_obst;
    logic [LANES-1:0]   latch_pkg;

    logic [LANES-1:0]   gen_obst;
    logic [LANES-1:0]   gen_pkg;
    logic [LANES-1:0]   ins_obst;
    logic [LANES-1:0]   ins_pkg;
    logic [LANES-1:0]   obst_row0;
    logic [LANES-1:0]   pkg_row0;
    logic [LANES-1:0]   lane_onehot;
    logic [MAP_W-1:0]   obst_nxt;
    logic [MAP_W-1:0]   pkg_nxt;
    logic               lane_ok;
    logic               collide;
    logic               collect;
    logic               do_shift;
    logic               has_obst;
    int                 obst_lane;
    int                 pkg_lane;
    logic               unused_lfsr;

    lfsr_16 #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:7];

    // Row generation: at most one obstacle; a package sharing the
    // obstacle's lane is dropped so every generated row stays passable.
    always_comb begin
        gen_obst  = '0;
        gen_pkg   = '0;
        has_obst  = (lfsr[3:2] != 2'b00);
        obst_lane = int'(lfsr[1:0]) % LANES;
        pkg_lane  = int'(lfsr[5:4]) % LANES;
        for (int l = 0; l < LANES; l++) begin
            if (has_obst && (l == obst_lane))
                gen_obst[l] = 1'b1;
            if (lfsr[6] && (l == pkg_lane) && !(has_obst && (pkg_lane == obst_lane)))
                gen_pkg[l] = 1'b1;
        end
    end

    // Player-row evaluation and next map contents
    always_comb begin
        obst_row0   = obstacles[LANES-1:0];
        pkg_row0    = packages[LANES-1:0];
        lane_onehot = '0;
        lane_onehot[player_lane] = 1'b1;
        lane_ok     = (int'(player_lane) < LANES);
        collide     = (state == RUN) && lane_ok && obst_row0[player_lane];
        collect     = (state == RUN) && lane_ok && pkg_row0[player_lane];
        do_shift    = (state == RUN) && move_map;
        ins_obst    = latch_vld ? latch_obst : gen_obst;
        ins_pkg     = latch_vld ? latch_pkg  : gen_pkg;
        obst_nxt    = obstacles;
        pkg_nxt     = packages;
        if (do_shift) begin
            // Shift wins over the clear: row 0 is discarded anyway
            obst_nxt = {ins_obst, obstacles[MAP_W-1:LANES]};
            pkg_nxt  = {ins_pkg,  packages[MAP_W-1:LANES]};
        end else begin
            if (collide)
                obst_nxt[LANES-1:0] = obst_row0 & ~lane_onehot;
            if (collect)
                pkg_nxt[LANES-1:0]  = pkg_row0 & ~lane_onehot;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            obstacles  <= '0;
            packages   <= '0;
            score      <= '0;
            lives      <= LIVES_INIT;
            hit        <= 1'b0;
            pickup     <= 1'b0;
            game_over  <= 1'b0;
            count_map  <= 1'b0;
            latch_vld  <= 1'b0;
            latch_obst <= '0;
            latch_pkg  <= '0;
        end else begin
            hit    <= 1'b0;
            pickup <= 1'b0;

            if (do_shift)
                latch_vld <= 1'b0;
            if (load_valid) begin
                latch_vld  <= 1'b1;
                latch_obst <= load_obst;
                latch_pkg  <= load_pkg;
            end

            case (state)
                RUN: begin
                    obstacles <= obst_nxt;
                    packages  <= pkg_nxt;
                    if (collide) begin
                        hit <= 1'b1;
                        if (lives == 3'd1) begin
                            lives     <= 3'd0;
                            state     <= OVER;
                            count_map <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            lives <= lives - 1'b1;
                        end
                    end
                    if (collect) begin
                        pickup <= 1'b1;
                        score  <= sat_inc(score);
                    end
                end
                default: begin
                    // IDLE and OVER: map frozen until a new game starts
                    if (start) begin
                        state     <= RUN;
                        count_map <= 1'b1;
                        game_over <= 1'b0;
                        obstacles <= '0;
                        packages  <= '0;
                        score     <= '0;
                        lives     <= LIVES_INIT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_scroller.sv
module tb_map_scroller;

    localparam int LANES = 4;
    localparam int ROWS  = 8;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   move_map = 1'b0;
    logic [1:0]             player_lane = 2'd0;
    logic                   load_valid = 1'b0;
    logic [LANES-1:0]       load_obst = '0;
    logic [LANES-1:0]       load_pkg = '0;
    logic                   count_map;
    logic [ROWS*LANES-1:0]  obstacles;
    logic [ROWS*LANES-1:0]  packages;
    logic [7:0]             score;
    logic [2:0]             lives;
    logic                   hit;
    logic                   pickup;
    logic                   game_over;

    map_scroller #(
        .LANES(LANES), .ROWS(ROWS), .LIVES(3), .SCORE_W(8), .SEED(16'hACE1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .move_map    (move_map),
        .player_lane (player_lane),
        .load_valid  (load_valid),
        .load_obst   (load_obst),
        .load_pkg    (load_pkg),
        .count_map   (count_map),
        .obstacles   (obstacles),
        .packages    (packages),
        .score       (score),
        .lives       (lives),
        .hit         (hit),
        .pickup      (pickup),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] obst;
        logic [31:0] pkg;
        logic [7:0]  score;
        logic [2:0]  lives;
        logic        hit;
        logic        pick;
        logic        over;
        logic        running;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: the map as an array of rows, game phase as flags
    logic [3:0]  m_obst [ROWS];
    logic [3:0]  m_pkg  [ROWS];
    int          m_score;
    int          m_lives;
    bit          m_running;
    bit          m_over;
    bit          m_hit;
    bit          m_pick;
    logic [15:0] m_lfsr;
    bit          m_lv;
    logic [3:0]  m_lo;
    logic [3:0]  m_lp;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic m_reset();
        for (int r = 0; r < ROWS; r++) begin
            m_obst[r] = '0;
            m_pkg[r]  = '0;
        end
        m_score = 0; m_lives = 3; m_running = 0; m_over = 0;
        m_hit = 0; m_pick = 0; m_lfsr = 16'hACE1;
        m_lv = 0; m_lo = '0; m_lp = '0;
    endtask

    task automatic model_step(input bit rn, input bit st, input bit mv,
                              input logic [1:0] ln, input bit lv,
                              input logic [3:0] lo, input logic [3:0] lp);
        int ol, pl;
        bit has_o, has_p, c, p;
        logic [3:0] go, gp;
        if (!rn) begin
            m_reset();
            return;
        end
        m_hit = 0;
        m_pick = 0;
        ol    = int'(m_lfsr[1:0]);
        pl    = int'(m_lfsr[5:4]);
        has_o = (m_lfsr[3:2] != 2'b00);
        has_p = m_lfsr[6] && !(has_o && (pl == ol));
        go    = has_o ? 4'(1 << ol) : 4'd0;
        gp    = has_p ? 4'(1 << pl) : 4'd0;
        if (m_running) begin
            c = m_obst[0][ln];
            p = m_pkg[0][ln];
            if (c) begin
                m_hit = 1;
                m_lives = m_lives - 1;
                if (m_lives == 0) begin
                    m_running = 0;
                    m_over = 1;
                end
            end
            if (p) begin
                m_pick = 1;
                if (m_score < 255) m_score = m_score + 1;
            end
            if (mv) begin
                for (int r = 0; r < ROWS - 1; r++) begin
                    m_obst[r] = m_obst[r+1];
                    m_pkg[r]  = m_pkg[r+1];
                end
                m_obst[ROWS-1] = m_lv ? m_lo : go;
                m_pkg[ROWS-1]  = m_lv ? m_lp : gp;
                m_lv = 0;
            end else begin
                if (c) m_obst[0][ln] = 1'b0;
                if (p) m_pkg[0][ln]  = 1'b0;
            end
        end else if (st) begin
            m_running = 1;
            m_over = 0;
            for (int r = 0; r < ROWS; r++) begin
                m_obst[r] = '0;
                m_pkg[r]  = '0;
            end
            m_score = 0;
            m_lives = 3;
        end
        if (lv) begin
            m_lv = 1; m_lo = lo; m_lp = lp;
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic push_expected();
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.obst[r*4 +: 4] = m_obst[r];
            e.pkg[r*4 +: 4]  = m_pkg[r];
        end
        e.score   = 8'(m_score);
        e.lives   = 3'(m_lives);
        e.hit     = m_hit;
        e.pick    = m_pick;
        e.over    = m_over;
        e.running = m_running;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive at the falling edge, predict the state
    // after the following rising edge.
    task automatic tick(input bit rn, input bit st, input bit mv,
                        input logic [1:0] ln, input bit lv,
                        input logic [3:0] lo, input logic [3:0] lp);
        @(negedge clock);
        reset = rn; start = st; move_map = mv; player_lane = ln;
        load_valid = lv; load_obst = lo; load_pkg = lp;
        model_step(rn, st, mv, ln, lv, lo, lp);
        push_expected();
    endtask

    task automatic idle(input int n, input logic [1:0] ln);
        for (int i = 0; i < n; i++) tick(1, 0, 0, ln, 0, 4'd0, 4'd0);
    endtask

    task automatic shift_forced(input logic [3:0] lo, input logic [3:0] lp, input logic [1:0] ln);
        tick(1, 0, 0, ln, 1, lo, lp);
        tick(1, 0, 1, ln, 0, 4'd0, 4'd0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Monitor: compares DUT outputs one time unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("obstacles", obstacles, e.obst);
                chk("packages",  packages,  e.pkg);
                chk("score",     32'(score), 32'(e.score));
                chk("lives",     32'(lives), 32'(e.lives));
                chk("hit",       32'(hit),    32'(e.hit));
                chk("pickup",    32'(pickup), 32'(e.pick));
                chk("game_over", 32'(game_over), 32'(e.over));
                chk("count_map", 32'(count_map), 32'(e.running));
            end
        end
    end

    initial begin
        m_reset();
        // Reset held, then released with no start and scroll pulses
        tick(0, 0, 0, 2'd0, 0, 4'd0, 4'd0);
        tick(0, 0, 1, 2'd0, 0, 4'd0, 4'd0);
        for (int i = 0; i < 20; i++) tick(1, 0, 1, 2'd0, 0, 4'd0, 4'd0);

        // Start; forced obstacle in lane 2 reaches row 0 after 8 shifts
        tick(1, 1, 0, 2'd2, 0, 4'd0, 4'd0);
        shift_forced(4'b0100, 4'd0, 2'd2);
        tick(1, 1, 0, 2'd2, 1, 4'd0, 4'd0);   // start held in RUN is ignored
        tick(1, 1, 1, 2'd2, 0, 4'd0, 4'd0);
        for (int i = 0; i < 6; i++) shift_forced(4'd0, 4'd0, 2'd2);
        idle(6, 2'd2);

        // Package in lane 0 collected
        shift_forced(4'd0, 4'b0001, 2'd0);
        for (int i = 0; i < 7; i++) shift_forced(4'd0, 4'd0, 2'd0);
        idle(3, 2'd0);
        // Package in lane 0 missed from lane 1, then scrolled away
        shift_forced(4'd0, 4'b0001, 2'd1);
        for (int i = 0; i < 7; i++) shift_forced(4'd0, 4'd0, 2'd1);
        idle(3, 2'd1);
        shift_forced(4'd0, 4'd0, 2'd1);
        idle(2, 2'd1);

        // Obstacle in row 0 lane 1 hit in the same cycle as a shift
        shift_forced(4'b0010, 4'd0, 2'd0);
        for (int i = 0; i < 7; i++) shift_forced(4'd0, 4'd0, 2'd0);
        tick(1, 0, 1, 2'd1, 0, 4'd0, 4'd0);
        idle(2, 2'd0);

        // Repeated collisions in lane 3 until the game ends
        for (int i = 0; i < 8; i++) shift_forced(4'b1000, 4'd0, 2'd0);
        idle(2, 2'd3);
        shift_forced(4'b1000, 4'd0, 2'd3);
        shift_forced(4'b1000, 4'd0, 2'd3);
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 2'd3, 0, 4'd0, 4'd0);
        tick(1, 1, 0, 2'd0, 0, 4'd0, 4'd0);   // restart
        idle(2, 2'd0);

        // Score saturation: a package reaches row 0 on every shift
        for (int i = 0; i < 270; i++) shift_forced(4'd0, 4'b0001, 2'd0);
        idle(2, 2'd0);

        // Reset in the middle of a game
        tick(0, 0, 1, 2'd0, 0, 4'd0, 4'd0);
        tick(1, 1, 0, 2'd0, 0, 4'd0, 4'd0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            bit rn, st, mv, lv;
            rn = ($urandom_range(0, 599) != 0);
            st = ($urandom_range(0, 24) == 0);
            mv = ($urandom_range(0, 2) == 0);
            lv = !mv && ($urandom_range(0, 3) == 0);
            tick(rn, st, mv, 2'($urandom_range(0, 3)), lv,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        @(posedge clock);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
